// File: rtl/matrix_row_arbiter.sv
// rtl/matrix_row_arbiter.sv - round-robin burst reader sharing the matrix row memory between two requesters
// One Avalon read outstanding at a time; each returned row is registered and pulsed to the granted requester.
module matrix_row_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ROWS      = 8,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [2:0]        req0_row,
  input  logic [3:0]        req0_count,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [2:0]        req1_row,
  input  logic [3:0]        req1_count,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic [2:0]        rsp0_row,
  output logic              rsp0_last,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [2:0]        rsp1_row,
  output logic              rsp1_last,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic              busy
);

  localparam int               TMR_W    = $clog2(TIMEOUT) + 1;
  localparam logic [3:0]       MAX_CNT  = 4'(ROWS);
  localparam logic [2:0]       LAST_ROW = 3'(ROWS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD} state_t;

  state_t              r_state;
  logic                r_last_grant;
  logic                r_owner;
  logic [2:0]          r_cur_row;
  logic [3:0]          r_remaining;
  logic [TMR_W-1:0]    r_timer;
  logic                r_avm_read;
  logic [ADDR_W-1:0]   r_avm_address;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [2:0]          r_rsp_row;
  logic                r_rsp_last;
  logic                r_rsp_err;

  logic                w_idle;
  logic                w_grant0;
  logic                w_grant1;
  logic                w_any_grant;
  logic [2:0]          w_sel_row;
  logic [3:0]          w_sel_raw;
  logic [3:0]          w_sel_cnt;
  logic [2:0]          w_next_row;

  function automatic logic [ADDR_W-1:0] f_row_addr(input logic [2:0] row);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(row);
  endfunction

  // Tie goes to the requester that was not granted last.
  assign w_idle      = reset_n && (r_state == S_IDLE);
  assign w_grant0    = w_idle && req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1    = w_idle && req1_valid && (!req0_valid || !r_last_grant);
  assign w_any_grant = w_grant0 || w_grant1;
  assign w_sel_row   = w_grant1 ? req1_row : req0_row;
  assign w_sel_raw   = w_grant1 ? req1_count : req0_count;
  assign w_sel_cnt   = (w_sel_raw > MAX_CNT) ? MAX_CNT : w_sel_raw;
  assign w_next_row  = (r_cur_row == LAST_ROW) ? 3'd0 : r_cur_row + 3'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_owner       <= 1'b0;
      r_cur_row     <= 3'd0;
      r_remaining   <= 4'd0;
      r_timer       <= '0;
      r_avm_read    <= 1'b0;
      r_avm_address <= ADDR_W'(BASE_ADDR);
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_row     <= 3'd0;
      r_rsp_last    <= 1'b0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_grant) begin
            r_last_grant <= w_grant1;
            r_owner      <= w_grant1;
            r_cur_row    <= w_sel_row;
            r_remaining  <= w_sel_cnt;
            if (w_sel_cnt == 4'd0) begin
              r_rsp_valid <= 1'b1;
              r_rsp_last  <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_row   <= w_sel_row;
            end else begin
              r_state       <= S_ISSUE;
              r_avm_read    <= 1'b1;
              r_avm_address <= f_row_addr(w_sel_row);
            end
          end
        end
        S_ISSUE: begin
          if (!avm_waitrequest) begin
            r_avm_read <= 1'b0;
            r_timer    <= '0;
            r_state    <= S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          if (avm_readdatavalid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= avm_readdata;
            r_rsp_row   <= r_cur_row;
            r_rsp_last  <= (r_remaining == 4'd1);
            r_cur_row   <= w_next_row;
            r_remaining <= r_remaining - 4'd1;
            if (r_remaining == 4'd1) begin
              r_state <= S_IDLE;
            end else begin
              r_state       <= S_ISSUE;
              r_avm_read    <= 1'b1;
              r_avm_address <= f_row_addr(w_next_row);
            end
          end else if (r_timer == TMR_LAST) begin
            // Slave went silent: close the burst with an error beat and drop the remaining rows.
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_row   <= r_cur_row;
            r_remaining <= 4'd0;
            r_state     <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign rsp0_valid  = r_rsp_valid && !r_owner;
  assign rsp1_valid  = r_rsp_valid && r_owner;
  assign rsp0_last   = rsp0_valid && r_rsp_last;
  assign rsp1_last   = rsp1_valid && r_rsp_last;
  assign rsp0_err    = rsp0_valid && r_rsp_err;
  assign rsp1_err    = rsp1_valid && r_rsp_err;
  assign rsp0_data   = r_rsp_data;
  assign rsp1_data   = r_rsp_data;
  assign rsp0_row    = r_rsp_row;
  assign rsp1_row    = r_rsp_row;
  assign avm_read    = r_avm_read;
  assign avm_address = r_avm_address;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_matrix_row_arbiter.sv
// tb/tb_matrix_row_arbiter.sv - randomized bench for matrix_row_arbiter against a burst-level reference model
// The model expands each accepted request into its expected beats; a simple Avalon slave serves the reads.
module tb_matrix_row_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int ROWS    = 8;
  localparam int BASE    = 'h40;
  localparam int TIMEOUT = 64;

  typedef struct {
    bit          owner;
    logic [2:0]  row;
    logic [63:0] data;
    bit          last;
    bit          err;
    bit          zc;
  } beat_t;

  typedef struct {
    logic [2:0] row;
    logic [3:0] cnt;
  } rq_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        req_valid = 2'b00;
  logic [2:0]        req_row [2];
  logic [3:0]        req_count [2];
  logic              req0_ready, req1_ready;
  logic              rsp0_valid, rsp1_valid, rsp0_last, rsp1_last, rsp0_err, rsp1_err;
  logic [DATA_W-1:0] rsp0_data, rsp1_data;
  logic [2:0]        rsp0_row, rsp1_row;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, busy;
  logic [DATA_W-1:0] avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;
  logic              avm_waitrequest = 1'b0;

  int          n_chk = 0, n_fail = 0, cyc = 0;
  beat_t       exp_q[$];
  rq_t         pq0[$], pq1[$];
  bit          model_last = 1'b1;
  logic [1:0]  accepted = 2'b00;
  logic [63:0] mem [8];
  int          acc_cnt = 0, data_beats = 0, to_beats = 0, acc_cyc = 0;
  int          slv_delay = 1, slv_stall = 0, s_cnt = 0, s_left = 0, s_idx = 0, wc = 0;
  bit          slv_mute = 0, slv_rand = 0, gap_rand = 0, force_rdv = 0;
  bit          s_pend = 0, s_stalling = 0;
  logic [31:0] s_hold = '0;

  matrix_row_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROWS(ROWS), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req_valid[0]), .req0_row(req_row[0]), .req0_count(req_count[0]), .req0_ready(req0_ready),
    .req1_valid(req_valid[1]), .req1_row(req_row[1]), .req1_count(req_count[1]), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_row(rsp0_row), .rsp0_last(rsp0_last), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_row(rsp1_row), .rsp1_last(rsp1_last), .rsp1_err(rsp1_err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_burst(input bit n, input logic [2:0] row, input logic [3:0] cnt);
    int k;
    logic [2:0] r;
    k = (int'(cnt) > ROWS) ? ROWS : int'(cnt);
    if (k == 0) exp_q.push_back('{n, row, 64'd0, 1'b1, 1'b1, 1'b1});
    else if (slv_mute) exp_q.push_back('{n, row, 64'd0, 1'b1, 1'b1, 1'b0});
    else begin
      for (int i = 0; i < k; i++) begin
        r = 3'((int'(row) + i) % ROWS);
        exp_q.push_back('{n, r, mem[r], (i == k - 1), 1'b0, 1'b0});
      end
    end
  endtask

  task automatic mon_rsp(input bit n, input logic v, input logic [63:0] d, input logic [2:0] r,
                         input logic l, input logic e);
    beat_t b;
    if (!v) return;
    if (exp_q.size() == 0) begin
      chk("rsp_unexpected", 64'(n), 64'(2));
      return;
    end
    b = exp_q.pop_front();
    chk("rsp_owner", 64'(n), 64'(b.owner));
    chk("rsp_last", 64'(l), 64'(b.last));
    chk("rsp_err", 64'(e), 64'(b.err));
    chk("rsp_data", d, b.data);
    if (!b.err) begin
      chk("rsp_row", 64'(r), 64'(b.row));
      data_beats++;
    end else if (!b.zc) begin
      to_beats++;
      chk("timeout_not_early", 64'(cyc - acc_cyc >= TIMEOUT + 1), 64'(1));
      chk("timeout_not_late", 64'(cyc - acc_cyc <= TIMEOUT + 2), 64'(1));
    end
  endtask

  task automatic mon_rdy(input bit n, input logic rdy);
    if (!rdy) return;
    chk("ready_needs_valid", 64'(req_valid[n]), 64'(1));
    chk("ready_while_burst", 64'(exp_q.size()), 64'(0));
    if (req_valid == 2'b11) chk("rr_winner", 64'(n), 64'(!model_last));
    model_last = n;
    accepted[n] = 1'b1;
    push_burst(n, req_row[n], req_count[n]);
  endtask

  // Response / grant monitor
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("rsp_one_port", 64'(rsp0_valid && rsp1_valid), 64'(0));
      mon_rsp(1'b0, rsp0_valid, rsp0_data, rsp0_row, rsp0_last, rsp0_err);
      mon_rsp(1'b1, rsp1_valid, rsp1_data, rsp1_row, rsp1_last, rsp1_err);
      chk("busy", 64'(busy), 64'(exp_q.size() > 0 && !exp_q[0].zc));
      chk("ready_one_port", 64'(req0_ready && req1_ready), 64'(0));
      mon_rdy(1'b0, req0_ready);
      mon_rdy(1'b1, req1_ready);
    end
  end

  // Avalon slave: optional waitrequest stall, fixed or random read latency, optional silence
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      avm_readdatavalid = 1'b0;
      avm_waitrequest = 1'b0;
      s_pend = 0;
      s_stalling = 0;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata = {$urandom, $urandom};
      avm_waitrequest = 1'b0;
      if (force_rdv) begin
        avm_readdatavalid = 1'b1;
        force_rdv = 0;
      end
      if (s_pend) begin
        s_cnt--;
        if (s_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = (s_idx >= 0 && s_idx < ROWS) ? mem[s_idx[2:0]] : {64{1'b1}};
          s_pend = 0;
        end
      end
      if (avm_read) begin
        chk("one_outstanding", 64'(s_pend), 64'(0));
        if (s_stalling) chk("addr_stable", 64'(avm_address), 64'(s_hold));
        else s_left = slv_rand ? int'($urandom_range(0, 3)) : slv_stall;
        if (s_left > 0) begin
          avm_waitrequest = 1'b1;
          s_left--;
          s_stalling = 1;
          s_hold = avm_address;
        end else begin
          s_stalling = 0;
          acc_cnt++;
          acc_cyc = cyc;
          s_idx = int'(avm_address) - BASE;
          if (!slv_mute) begin
            s_pend = 1;
            s_cnt = slv_rand ? int'($urandom_range(1, 4)) : slv_delay;
          end
        end
      end else if (s_stalling) begin
        chk("read_held_under_stall", 64'(0), 64'(1));
        s_stalling = 0;
      end
    end
  end

  task automatic drv(input bit n);
    rq_t q;
    if (accepted[n]) begin
      req_valid[n] = 1'b0;
      accepted[n] = 1'b0;
    end
    if (!req_valid[n] && (n ? pq1.size() : pq0.size()) > 0 && (!gap_rand || $urandom_range(0, 2) != 0)) begin
      if (n) q = pq1.pop_front();
      else q = pq0.pop_front();
      req_row[n] = q.row;
      req_count[n] = q.cnt;
      req_valid[n] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drv(1'b0);
    drv(1'b1);
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (c < budget && !(pq0.size() == 0 && pq1.size() == 0 && req_valid == 2'b00 &&
                           exp_q.size() == 0 && !s_pend)) begin
      step();
      c++;
    end
    chk("drain_in_budget", 64'(c < budget), 64'(1));
    repeat (3) step();
    chk("reads_vs_beats", 64'(acc_cnt), 64'(data_beats + to_beats));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    req_valid = 2'b00;
    accepted = 2'b00;
    pq0.delete();
    pq1.delete();
    exp_q.delete();
    model_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_avm_read", 64'(avm_read), 64'(0));
    chk("rst_avm_address", 64'(avm_address), 64'(BASE));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'(0));
    chk("rst_rsp_flags", 64'({rsp0_last, rsp0_err, rsp1_last, rsp1_err}), 64'(0));
    chk("rst_rsp_data", rsp0_data, 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    acc_cnt = 0;
    data_beats = 0;
    to_beats = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    req_row[0] = 3'd0; req_row[1] = 3'd0; req_count[0] = 4'd0; req_count[1] = 4'd0;
    for (int i = 0; i < ROWS; i++) mem[i] = {$urandom, 24'($urandom), 8'(i)};
    do_reset();

    // Full 8-row burst behind a slow slave
    slv_delay = 10;
    pq0.push_back('{3'd0, 4'd8});
    drain(400);

    // Simultaneous requests right after reset: req0 first, then req1
    do_reset();
    slv_delay = 2;
    pq0.push_back('{3'd3, 4'd2});
    pq1.push_back('{3'd5, 4'd3});
    drain(300);

    // Wrap past the last row
    pq1.push_back('{3'd6, 4'd4});
    drain(200);

    // Waitrequest held for five cycles on every read
    slv_stall = 5;
    slv_delay = 1;
    pq0.push_back('{3'd1, 4'd2});
    drain(200);
    slv_stall = 0;

    // Oversized count clamps to a full wrapped burst
    pq1.push_back('{3'd4, 4'd13});
    drain(300);

    // Silent slave: timeout error beat, remaining rows dropped
    slv_mute = 1;
    pq0.push_back('{3'd2, 4'd3});
    drain(300);
    slv_mute = 0;

    // Reset mid-burst, stale readdatavalid, then a zero-count request
    slv_delay = 3;
    pq0.push_back('{3'd0, 4'd8});
    wc = 0;
    while (acc_cnt < 3 && wc < 200) begin
      step();
      wc++;
    end
    chk("mid_burst_reached", 64'(wc < 200), 64'(1));
    do_reset();
    step();
    force_rdv = 1;
    repeat (5) step();
    pq1.push_back('{3'd3, 4'd0});
    drain(50);

    // Random traffic from both requesters
    gap_rand = 1;
    slv_rand = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) pq0.push_back('{3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))});
      else pq1.push_back('{3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))});
    end
    drain(20000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
